hpm_counter_bank: RTL and testbench

Parametrised hardware performance monitor bank: NUM_COUNTERS programmable event counters (mhpmcounter3..), each with its own event selector, global inhibit mask and sticky overflow.
- Sits beside the CSR file in the privileged unit.
- Claims its own CSR addresses through a flat request/ack port.
- Counts single-cycle event pulses from the pipeline.

---
 rtl/hpm_pkg.sv | 42 ++++
 rtl/hpm_counter.sv | 95 +++++++++
 rtl/hpm_counter_bank.sv | 166 ++++++++++++++++
 tb/tb_hpm_counter_bank.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hpm_pkg.sv
// ---------------------------------------------------------------------------
// hpm_pkg
// Shared definitions for the hardware performance monitor bank: CSR address
// bases, event selector width, address-decoder classification and the WARL
// legalisation helper for the event selector.
// ---------------------------------------------------------------------------
package hpm_pkg;

    localparam logic [11:0] MHPMCOUNTER_BASE  = 12'hB03;
    localparam logic [11:0] MHPMCOUNTERH_BASE = 12'hB83;
    localparam logic [11:0] HPMCOUNTER_BASE   = 12'hC03;
    localparam logic [11:0] HPMCOUNTERH_BASE  = 12'hC83;
    localparam logic [11:0] MHPMEVENT_BASE    = 12'h323;
    localparam logic [11:0] MCOUNTINHIBIT     = 12'h320;

    localparam int EVSEL_W = 8;

    // What kind of register the current CSR address selects.
    typedef enum logic [2:0] {
        NONE    = 3'd0,
        CNT_LO  = 3'd1,
        CNT_HI  = 3'd2,
        EVT     = 3'd3,
        INHIBIT = 3'd4
    } hpm_csr_kind_t;

    // Selector codes above the number of implemented events legalise to 0,
    // which parks the counter (it never increments).
    function automatic logic [EVSEL_W-1:0] evsel_warl(
        input logic [EVSEL_W-1:0] req,
        input int                 num_events
    );
        logic [EVSEL_W-1:0] res;
        if (int'(req) > num_events) begin
            res = {EVSEL_W{1'b0}};
        end else begin
            res = req;
        end
        return res;
    endfunction

endpackage

// File: rtl/hpm_counter.sv
// ---------------------------------------------------------------------------
// hpm_counter
// One programmable event counter: count value, event selector and sticky
// overflow flag.
//   clk, n_rst : clock, asynchronous active-low reset
//   inc        : count one event this edge
//   wr_lo      : write count[31:0] from wdata
//   wr_hi      : write count[COUNTER_WIDTH-1:32] from wdata
//   wr_evt     : write selector (wdata[7:0], WARL) and OF (wdata[31])
//   wdata      : CSR write data
//   count      : current count
//   sel        : current event selector
//   of         : sticky overflow flag
// ---------------------------------------------------------------------------
module hpm_counter
    import hpm_pkg::*;
#(
    parameter int COUNTER_WIDTH = 64,
    parameter int NUM_EVENTS    = 8
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     inc,
    input  logic                     wr_lo,
    input  logic                     wr_hi,
    input  logic                     wr_evt,
    input  logic [31:0]              wdata,
    output logic [COUNTER_WIDTH-1:0] count,
    output logic [EVSEL_W-1:0]       sel,
    output logic                     of
);

    localparam int HI_W = COUNTER_WIDTH - 32;

    logic [COUNTER_WIDTH-1:0] count_r;
    logic [COUNTER_WIDTH-1:0] count_next_s;
    logic [EVSEL_W-1:0]       sel_r;
    logic [EVSEL_W-1:0]       sel_next_s;
    logic                     of_r;
    logic                     of_next_s;
    logic                     wrap_s;

    // Next count: a software write replaces its half and drops any increment
    // on the same edge, so a carry never leaks into freshly written data.
    always_comb begin
        count_next_s = count_r;
        wrap_s       = 1'b0;
        if (wr_lo) begin
            count_next_s = {count_r[COUNTER_WIDTH-1:32], wdata};
        end else if (wr_hi) begin
            count_next_s = {wdata[HI_W-1:0], count_r[31:0]};
        end else if (inc) begin
            count_next_s = count_r + {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};
            wrap_s       = &count_r;
        end else begin
            count_next_s = count_r;
        end
    end

    // Next OF / selector: a hardware overflow beats a same-edge software clear.
    always_comb begin
        of_next_s  = of_r;
        sel_next_s = sel_r;
        if (wrap_s) begin
            of_next_s = 1'b1;
        end else if (wr_evt) begin
            of_next_s = wdata[31];
        end else begin
            of_next_s = of_r;
        end
        if (wr_evt) begin
            sel_next_s = evsel_warl(wdata[EVSEL_W-1:0], NUM_EVENTS);
        end else begin
            sel_next_s = sel_r;
        end
    end

    // Counter state registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_r <= {COUNTER_WIDTH{1'b0}};
            sel_r   <= {EVSEL_W{1'b0}};
            of_r    <= 1'b0;
        end else begin
            count_r <= count_next_s;
            sel_r   <= sel_next_s;
            of_r    <= of_next_s;
        end
    end

    assign count = count_r;
    assign sel   = sel_r;
    assign of    = of_r;

endmodule

// File: rtl/hpm_counter_bank.sv
// ---------------------------------------------------------------------------
// hpm_counter_bank
// Bank of NUM_COUNTERS programmable performance counters (mhpmcounter3..)
// with a flat CSR request/ack port.
//   clk, n_rst   : clock, asynchronous active-low reset
//   event_in     : single-cycle event pulses from the pipeline
//   csr_active   : CSR access this cycle; csr_write marks a write
//   csr_addr     : CSR address; csr_wdata : write data
//   csr_rdata    : read data (combinational, pre-write state)
//   csr_ack      : address belongs to this block
//   csr_invalid  : unclaimed address, or write to a read-only shadow
//   overflow_irq : per-counter sticky overflow flags
// ---------------------------------------------------------------------------
module hpm_counter_bank
    import hpm_pkg::*;
#(
    parameter int NUM_COUNTERS  = 4,
    parameter int NUM_EVENTS    = 8,
    parameter int COUNTER_WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic [NUM_EVENTS-1:0]   event_in,
    input  logic                    csr_active,
    input  logic                    csr_write,
    input  logic [11:0]             csr_addr,
    input  logic [31:0]             csr_wdata,
    output logic [31:0]             csr_rdata,
    output logic                    csr_ack,
    output logic                    csr_invalid,
    output logic [NUM_COUNTERS-1:0] overflow_irq
);

    logic [NUM_EVENTS-1:0]    event_q_r;
    logic [NUM_COUNTERS-1:0]  inhibit_r;

    logic [COUNTER_WIDTH-1:0] count_s [NUM_COUNTERS];
    logic [EVSEL_W-1:0]       sel_s   [NUM_COUNTERS];
    logic [31:0]              lo_s    [NUM_COUNTERS];
    logic [31:0]              hi_s    [NUM_COUNTERS];
    logic [31:0]              evt_s   [NUM_COUNTERS];
    logic [NUM_COUNTERS-1:0]  of_s;
    logic [NUM_COUNTERS-1:0]  inc_s;

    logic [NUM_COUNTERS-1:0]  hit_lo_s;
    logic [NUM_COUNTERS-1:0]  hit_hi_s;
    logic [NUM_COUNTERS-1:0]  hit_slo_s;
    logic [NUM_COUNTERS-1:0]  hit_shi_s;
    logic [NUM_COUNTERS-1:0]  hit_evt_s;
    logic                     hit_inh_s;
    logic                     wr_en_s;
    logic                     ro_s;
    hpm_csr_kind_t            kind_s;
    logic [31:0]              rdata_s;

    // Per-counter address match against every CSR window.
    always_comb begin
        hit_lo_s  = {NUM_COUNTERS{1'b0}};
        hit_hi_s  = {NUM_COUNTERS{1'b0}};
        hit_slo_s = {NUM_COUNTERS{1'b0}};
        hit_shi_s = {NUM_COUNTERS{1'b0}};
        hit_evt_s = {NUM_COUNTERS{1'b0}};
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            hit_lo_s[i]  = (csr_addr == MHPMCOUNTER_BASE  + 12'(i));
            hit_hi_s[i]  = (csr_addr == MHPMCOUNTERH_BASE + 12'(i));
            hit_slo_s[i] = (csr_addr == HPMCOUNTER_BASE   + 12'(i));
            hit_shi_s[i] = (csr_addr == HPMCOUNTERH_BASE  + 12'(i));
            hit_evt_s[i] = (csr_addr == MHPMEVENT_BASE    + 12'(i));
        end
        hit_inh_s = (csr_addr == MCOUNTINHIBIT);
    end

    // Classify the access; shadows decode as counter halves but are read-only.
    always_comb begin
        kind_s = NONE;
        ro_s   = (|hit_slo_s) | (|hit_shi_s);
        if ((|hit_lo_s) || (|hit_slo_s)) begin
            kind_s = CNT_LO;
        end else if ((|hit_hi_s) || (|hit_shi_s)) begin
            kind_s = CNT_HI;
        end else if (|hit_evt_s) begin
            kind_s = EVT;
        end else if (hit_inh_s) begin
            kind_s = INHIBIT;
        end else begin
            kind_s = NONE;
        end
    end

    assign wr_en_s = csr_active & csr_write;

    // Read mux: at most one hit is set, so OR-combining the windows is exact.
    always_comb begin
        rdata_s = 32'h0000_0000;
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            rdata_s = rdata_s
                    | (((hit_lo_s[i] | hit_slo_s[i])) ? lo_s[i]  : 32'h0000_0000)
                    | (((hit_hi_s[i] | hit_shi_s[i])) ? hi_s[i]  : 32'h0000_0000)
                    | ((hit_evt_s[i])                 ? evt_s[i] : 32'h0000_0000);
        end
        if (hit_inh_s) begin
            rdata_s = rdata_s | 32'({inhibit_r, 3'b000});
        end else begin
            rdata_s = rdata_s;
        end
    end

    assign csr_rdata    = csr_active ? rdata_s : 32'h0000_0000;
    assign csr_ack      = csr_active & (kind_s != NONE);
    assign csr_invalid  = csr_active & ((kind_s == NONE) | (ro_s & csr_write));
    assign overflow_irq = of_s;

    // Event pulses are registered once before they reach the counters.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            event_q_r <= {NUM_EVENTS{1'b0}};
        end else begin
            event_q_r <= event_in;
        end
    end

    // mcountinhibit: only bits 3.. are implemented, one per counter.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            inhibit_r <= {NUM_COUNTERS{1'b0}};
        end else if (wr_en_s && hit_inh_s) begin
            inhibit_r <= csr_wdata[3 +: NUM_COUNTERS];
        end else begin
            inhibit_r <= inhibit_r;
        end
    end

    for (genvar g = 0; g < NUM_COUNTERS; g++) begin : g_cnt
        logic ev_hit_s;

        // Pick the registered event the selector points at; code 0 matches none.
        always_comb begin
            ev_hit_s = 1'b0;
            for (int k = 0; k < NUM_EVENTS; k++) begin
                ev_hit_s = ev_hit_s | ((sel_s[g] == EVSEL_W'(k + 1)) & event_q_r[k]);
            end
        end

        assign inc_s[g] = ev_hit_s & ~inhibit_r[g];
        assign lo_s[g]  = count_s[g][31:0];
        assign hi_s[g]  = 32'(count_s[g] >> 32);
        assign evt_s[g] = {of_s[g], 23'h00_0000, sel_s[g]};

        hpm_counter #(
            .COUNTER_WIDTH (COUNTER_WIDTH),
            .NUM_EVENTS    (NUM_EVENTS)
        ) u_counter (
            .clk    (clk),
            .n_rst  (n_rst),
            .inc    (inc_s[g]),
            .wr_lo  (wr_en_s & hit_lo_s[g]),
            .wr_hi  (wr_en_s & hit_hi_s[g]),
            .wr_evt (wr_en_s & hit_evt_s[g]),
            .wdata  (csr_wdata),
            .count  (count_s[g]),
            .sel    (sel_s[g]),
            .of     (of_s[g])
        );
    end

endmodule

// File: tb/tb_hpm_counter_bank.sv
module tb_hpm_counter_bank;

    localparam int NC = 4;
    localparam int NE = 8;
    localparam int CW = 64;

    logic          clk = 1'b0;
    logic          n_rst;
    logic [NE-1:0] event_in;
    logic          csr_active;
    logic          csr_write;
    logic [11:0]   csr_addr;
    logic [31:0]   csr_wdata;
    logic [31:0]   csr_rdata;
    logic          csr_ack;
    logic          csr_invalid;
    logic [NC-1:0] overflow_irq;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state (architectural view).
    logic [63:0] m_cnt [NC];
    int          m_sel [NC];
    bit          m_of  [NC];
    bit          m_inh [NC];
    logic [7:0]  m_evq;

    always #5 clk = ~clk;

    hpm_counter_bank #(
        .NUM_COUNTERS  (NC),
        .NUM_EVENTS    (NE),
        .COUNTER_WIDTH (CW)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .event_in     (event_in),
        .csr_active   (csr_active),
        .csr_write    (csr_write),
        .csr_addr     (csr_addr),
        .csr_wdata    (csr_wdata),
        .csr_rdata    (csr_rdata),
        .csr_ack      (csr_ack),
        .csr_invalid  (csr_invalid),
        .overflow_irq (overflow_irq)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void m_reset();
        for (int i = 0; i < NC; i++) begin
            m_cnt[i] = 64'h0;
            m_sel[i] = 0;
            m_of[i]  = 1'b0;
            m_inh[i] = 1'b0;
        end
        m_evq = 8'h00;
    endfunction

    // Expected combinational CSR response from the architectural state.
    function automatic void m_expect(output logic [31:0] rd, output logic ack, output logic inv);
        int a;
        int idx;
        bit hit;
        bit ro;
        logic [31:0] v;
        logic [63:0] c;
        rd  = 32'h0;
        ack = 1'b0;
        inv = 1'b0;
        if (csr_active) begin
            a   = int'(csr_addr);
            hit = 1'b0;
            ro  = 1'b0;
            v   = 32'h0;
            if (a >= 'hB03 && a < 'hB03 + NC) begin
                idx = a - 'hB03; c = m_cnt[idx]; hit = 1'b1; v = c[31:0];
            end else if (a >= 'hC03 && a < 'hC03 + NC) begin
                idx = a - 'hC03; c = m_cnt[idx]; hit = 1'b1; ro = 1'b1; v = c[31:0];
            end else if (a >= 'hB83 && a < 'hB83 + NC) begin
                idx = a - 'hB83; c = m_cnt[idx]; hit = 1'b1; v = c[63:32];
            end else if (a >= 'hC83 && a < 'hC83 + NC) begin
                idx = a - 'hC83; c = m_cnt[idx]; hit = 1'b1; ro = 1'b1; v = c[63:32];
            end else if (a >= 'h323 && a < 'h323 + NC) begin
                idx = a - 'h323; hit = 1'b1; v = {m_of[idx], 23'h0, 8'(m_sel[idx])};
            end else if (a == 'h320) begin
                hit = 1'b1;
                for (int i = 0; i < NC; i++) v[3 + i] = m_inh[i];
            end
            ack = hit;
            inv = !hit || (ro && csr_write);
            rd  = hit ? v : 32'h0;
        end
    endfunction

    // Advance the model across one rising edge using the current inputs.
    function automatic void m_step();
        bit inc [NC];
        bit we;
        bit hw_of;
        int a;
        a  = int'(csr_addr);
        we = csr_active && csr_write;
        for (int i = 0; i < NC; i++)
            inc[i] = (m_sel[i] != 0) && m_evq[m_sel[i] - 1] && !m_inh[i];
        for (int i = 0; i < NC; i++) begin
            hw_of = 1'b0;
            if (we && a == 'hB03 + i)
                m_cnt[i] = {m_cnt[i][63:32], csr_wdata};
            else if (we && a == 'hB83 + i)
                m_cnt[i] = {csr_wdata, m_cnt[i][31:0]};
            else if (inc[i]) begin
                if (m_cnt[i] == 64'hFFFF_FFFF_FFFF_FFFF) hw_of = 1'b1;
                m_cnt[i] = m_cnt[i] + 64'd1;
            end
            if (hw_of) m_of[i] = 1'b1;
            else if (we && a == 'h323 + i) m_of[i] = csr_wdata[31];
            if (we && a == 'h323 + i)
                m_sel[i] = (int'(csr_wdata[7:0]) > NE) ? 0 : int'(csr_wdata[7:0]);
        end
        if (we && a == 'h320)
            for (int i = 0; i < NC; i++) m_inh[i] = csr_wdata[3 + i];
        m_evq = event_in;
    endfunction

    // Compare process: check every cycle on the falling edge, then advance.
    initial begin : compare
        logic [31:0]   e_rd;
        logic          e_ack;
        logic          e_inv;
        logic [NC-1:0] e_irq;
        m_reset();
        forever begin
            @(negedge clk);
            if (!n_rst) m_reset();
            m_expect(e_rd, e_ack, e_inv);
            for (int i = 0; i < NC; i++) e_irq[i] = m_of[i];
            chk("model_rdata", 64'(csr_rdata), 64'(e_rd));
            chk("model_ack", 64'(csr_ack), 64'(e_ack));
            chk("model_invalid", 64'(csr_invalid), 64'(e_inv));
            chk("model_irq", 64'(overflow_irq), 64'(e_irq));
            if (n_rst) m_step();
        end
    end

    task automatic cyc(input logic [7:0] ev, input logic act, input logic wr,
                       input logic [11:0] a, input logic [31:0] d);
        event_in   = ev;
        csr_active = act;
        csr_write  = wr;
        csr_addr   = a;
        csr_wdata  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        cyc(8'h00, 1'b1, 1'b1, a, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(8'h00, 1'b0, 1'b0, 12'h000, 32'h0);
    endtask

    task automatic rd_chk(input logic [11:0] a, input logic [31:0] exp, input string name);
        event_in   = 8'h00;
        csr_active = 1'b1;
        csr_write  = 1'b0;
        csr_addr   = a;
        csr_wdata  = 32'h0;
        #2;
        chk(name, 64'(csr_rdata), 64'(exp));
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        n_rst      = 1'b0;
        event_in   = 8'h00;
        csr_active = 1'b0;
        csr_write  = 1'b0;
        csr_addr   = 12'h000;
        csr_wdata  = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;

        // Reset state
        chk("rst_irq", 64'(overflow_irq), 64'h0);
        rd_chk(12'hB03, 32'h0, "rst_cnt0");

        // Count 10 pulses of event 2 on counter 0
        wr(12'h323, 32'h2);
        for (int i = 0; i < 10; i++) cyc(8'h02, 1'b0, 1'b0, 12'h000, 32'h0);
        idle(2);
        rd_chk(12'hB03, 32'd10, "cnt10_lo");
        rd_chk(12'hC03, 32'd10, "cnt10_shadow");
        rd_chk(12'hB83, 32'd0, "cnt10_hi");

        // Inhibit
        wr(12'hB03, 32'h0);
        wr(12'h323, 32'h1);
        wr(12'h320, 32'h8);
        rd_chk(12'h320, 32'h8, "inh_readback");
        for (int i = 0; i < 5; i++) cyc(8'h01, 1'b0, 1'b0, 12'h000, 32'h0);
        idle(2);
        rd_chk(12'hB03, 32'd0, "inhibited");
        wr(12'h320, 32'h0);
        for (int i = 0; i < 5; i++) cyc(8'h01, 1'b0, 1'b0, 12'h000, 32'h0);
        idle(2);
        rd_chk(12'hB03, 32'd5, "uninhibited");

        // Wrap and sticky overflow
        wr(12'hB83, 32'hFFFF_FFFF);
        wr(12'hB03, 32'hFFFF_FFFE);
        wr(12'h323, 32'h1);
        for (int i = 0; i < 3; i++) cyc(8'h01, 1'b0, 1'b0, 12'h000, 32'h0);
        idle(2);
        rd_chk(12'hB03, 32'h1, "wrap_lo");
        rd_chk(12'hB83, 32'h0, "wrap_hi");
        chk("wrap_of", 64'(overflow_irq[0]), 64'h1);
        rd_chk(12'h323, 32'h8000_0001, "wrap_evt");
        wr(12'h323, 32'h1);
        chk("of_clear", 64'(overflow_irq[0]), 64'h0);

        // Lower-half write on the same edge as an increment
        wr(12'hB83, 32'h0);
        wr(12'hB03, 32'hFFFF_FFFF);
        cyc(8'h01, 1'b0, 1'b0, 12'h000, 32'h0);
        wr(12'hB03, 32'h1234_5678);
        idle(2);
        rd_chk(12'hB03, 32'h1234_5678, "wr_vs_inc_lo");
        rd_chk(12'hB83, 32'h0, "wr_vs_inc_hi");

        // WARL selector, read-only shadow, unclaimed address
        wr(12'h323, 32'h55);
        rd_chk(12'h323, 32'h0, "warl_sel");
        event_in = 8'h00; csr_active = 1'b1; csr_write = 1'b1;
        csr_addr = 12'hC03; csr_wdata = 32'hABCD;
        #2;
        chk("ro_ack", 64'(csr_ack), 64'h1);
        chk("ro_invalid", 64'(csr_invalid), 64'h1);
        @(posedge clk); #1;
        rd_chk(12'hB03, 32'h1234_5678, "ro_nochange");
        csr_active = 1'b1; csr_write = 1'b0; csr_addr = 12'hB10;
        #2;
        chk("unclaimed_ack", 64'(csr_ack), 64'h0);
        chk("unclaimed_invalid", 64'(csr_invalid), 64'h1);
        chk("unclaimed_rdata", 64'(csr_rdata), 64'h0);
        @(posedge clk); #1;

        // Mid-stream reset with counters running and an overflow pending
        wr(12'hB84, 32'hFFFF_FFFF);
        wr(12'hB04, 32'hFFFF_FFFF);
        wr(12'h323, 32'h1);
        wr(12'h324, 32'h2);
        for (int i = 0; i < 3; i++) cyc(8'h03, 1'b0, 1'b0, 12'h000, 32'h0);
        idle(2);
        chk("pre_rst_of1", 64'(overflow_irq[1]), 64'h1);
        rd_chk(12'hB04, 32'h2, "pre_rst_cnt1");
        cyc(8'h03, 1'b0, 1'b0, 12'h000, 32'h0);
        event_in = 8'h03;
        n_rst    = 1'b0;
        #2;
        chk("in_rst_irq", 64'(overflow_irq), 64'h0);
        @(posedge clk); #1;
        n_rst = 1'b1;
        idle(2);
        for (int i = 0; i < NC; i++) begin
            rd_chk(12'hB03 + 12'(i), 32'h0, "post_rst_lo");
            rd_chk(12'hB83 + 12'(i), 32'h0, "post_rst_hi");
            rd_chk(12'h323 + 12'(i), 32'h0, "post_rst_evt");
        end
        rd_chk(12'h320, 32'h0, "post_rst_inh");
        chk("post_rst_irq", 64'(overflow_irq), 64'h0);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
